// File: rtl/mc_rv_pkg.sv
// Shared types and constants for the multi-cycle RV32I-subset core.
package mc_rv_pkg;

  // Major opcodes of the supported subset.
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_B   = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  // Operations of the single shared ALU.
  typedef enum logic [2:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_AND,
    ALU_OR,
    ALU_SLT
  } alu_op_e;

  // Control FSM states.
  typedef enum logic [2:0] {
    FETCH,
    DECODE,
    EXEC,
    MEM,
    WB,
    HALT
  } state_e;

  // Decoded instruction class; CLS_ILL covers every unsupported encoding.
  typedef enum logic [2:0] {
    CLS_R,
    CLS_ADDI,
    CLS_LW,
    CLS_SW,
    CLS_BEQ,
    CLS_BNE,
    CLS_JAL,
    CLS_ILL
  } instr_cls_e;

endpackage

// File: rtl/mc_regfile.sv
// 32 x XLEN register file: two asynchronous read ports, one synchronous
// write port, x0 reads as zero and ignores writes.
module mc_regfile
  import mc_rv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            i_clk,
  input  logic [4:0]      i_raddr1,
  input  logic [4:0]      i_raddr2,
  output logic [XLEN-1:0] o_rdata1,
  output logic [XLEN-1:0] o_rdata2,
  input  logic            i_we,
  input  logic [4:0]      i_waddr,
  input  logic [XLEN-1:0] i_wdata
);

  logic [XLEN-1:0] r_regs [32];

  // Write port; writes to x0 are dropped.
  // NOTE: the array has no reset on purpose -- software must initialise
  // registers, and a reset here would force flops instead of a RAM macro.
  always_ff @(posedge i_clk) begin
    if (i_we && (i_waddr != 5'd0)) begin
      r_regs[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata1 = (i_raddr1 == 5'd0) ? '0 : r_regs[i_raddr1];
  assign o_rdata2 = (i_raddr2 == 5'd0) ? '0 : r_regs[i_raddr2];

endmodule

// File: rtl/multicycle_rv_core.sv
// Multi-cycle RV32I-subset core: one FSM, one shared ALU and one
// request/ready memory port used for both fetch and data access.
module multicycle_rv_core
  import mc_rv_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int ADDR_W   = 16,
  parameter int RESET_PC = 0
) (
  input  logic              Clk,
  input  logic              Rst,
  output logic              Mem_Req,
  output logic              Mem_We,
  output logic [ADDR_W-1:0] Mem_Addr,
  output logic [XLEN-1:0]   Mem_Wdata,
  input  logic              Mem_Ready,
  input  logic [XLEN-1:0]   Mem_Rdata,
  output logic              Halted,
  output logic [31:0]       Instret,
  output logic [ADDR_W-1:0] Dbg_PC
);

  state_e            r_state;
  logic [ADDR_W-1:0] r_pc;
  logic [XLEN-1:0]   r_ir;
  logic [XLEN-1:0]   r_a;
  logic [XLEN-1:0]   r_b;
  logic [XLEN-1:0]   r_imm;
  logic [XLEN-1:0]   r_alu_out;
  logic [XLEN-1:0]   r_mdr;
  logic              r_mem_req;
  logic              r_mem_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [XLEN-1:0]   r_mem_wdata;
  logic              r_halted;
  logic [31:0]       r_instret;

  logic [6:0]        w_opcode;
  logic [2:0]        w_funct3;
  logic [6:0]        w_funct7;
  logic [4:0]        w_rs1;
  logic [4:0]        w_rs2;
  logic [4:0]        w_rd;
  instr_cls_e        w_cls;
  alu_op_e           w_alu_op;
  logic [XLEN-1:0]   w_imm;
  logic [XLEN-1:0]   w_alu_b;
  logic [XLEN-1:0]   w_alu_result;
  logic [XLEN-1:0]   w_rs1_data;
  logic [XLEN-1:0]   w_rs2_data;
  logic [ADDR_W-1:0] w_pc_plus4;
  logic [ADDR_W-1:0] w_pc_target;
  logic              w_taken;
  logic              w_rf_we;
  logic [XLEN-1:0]   w_rf_wdata;

  assign w_opcode = r_ir[6:0];
  assign w_rd     = r_ir[11:7];
  assign w_funct3 = r_ir[14:12];
  assign w_rs1    = r_ir[19:15];
  assign w_rs2    = r_ir[24:20];
  assign w_funct7 = r_ir[31:25];

  // Decode the latched instruction into a class, ALU op and immediate.
  // NOTE: every output gets a default first so no path leaves it unassigned
  // and no latch is inferred.
  always_comb begin
    w_cls    = CLS_ILL;
    w_alu_op = ALU_ADD;
    w_imm    = '0;
    case (w_opcode)
      OP_R: begin
        if (w_funct7 == 7'b0000000) begin
          w_cls = CLS_R;
          case (w_funct3)
            3'b000:  w_alu_op = ALU_ADD;
            3'b111:  w_alu_op = ALU_AND;
            3'b110:  w_alu_op = ALU_OR;
            3'b010:  w_alu_op = ALU_SLT;
            default: w_cls    = CLS_ILL;
          endcase
        end else if ((w_funct7 == 7'b0100000) && (w_funct3 == 3'b000)) begin
          w_cls    = CLS_R;
          w_alu_op = ALU_SUB;
        end
      end
      OP_I: begin
        if (w_funct3 == 3'b000) w_cls = CLS_ADDI;
        w_imm = {{(XLEN-12){r_ir[31]}}, r_ir[31:20]};
      end
      OP_LW: begin
        if (w_funct3 == 3'b010) w_cls = CLS_LW;
        w_imm = {{(XLEN-12){r_ir[31]}}, r_ir[31:20]};
      end
      OP_SW: begin
        if (w_funct3 == 3'b010) w_cls = CLS_SW;
        w_imm = {{(XLEN-12){r_ir[31]}}, r_ir[31:25], r_ir[11:7]};
      end
      OP_B: begin
        if (w_funct3 == 3'b000) w_cls = CLS_BEQ;
        else if (w_funct3 == 3'b001) w_cls = CLS_BNE;
        w_imm = {{(XLEN-12){r_ir[31]}}, r_ir[7], r_ir[30:25], r_ir[11:8], 1'b0};
      end
      OP_JAL: begin
        w_cls = CLS_JAL;
        w_imm = {{(XLEN-20){r_ir[31]}}, r_ir[19:12], r_ir[20], r_ir[30:21], 1'b0};
      end
      default: ;
    endcase
  end

  // Shared ALU: register-register for R-type, register-immediate otherwise
  // (addi and the lw/sw effective address).
  assign w_alu_b = (w_cls == CLS_R) ? r_b : r_imm;

  always_comb begin
    w_alu_result = '0;
    case (w_alu_op)
      ALU_ADD: w_alu_result = r_a + w_alu_b;
      ALU_SUB: w_alu_result = r_a - w_alu_b;
      ALU_AND: w_alu_result = r_a & w_alu_b;
      ALU_OR:  w_alu_result = r_a | w_alu_b;
      ALU_SLT: w_alu_result = {{(XLEN-1){1'b0}}, $signed(r_a) < $signed(w_alu_b)};
      default: w_alu_result = '0;
    endcase
  end

  // PC arithmetic lives in the ADDR_W domain so it wraps there.
  assign w_pc_plus4  = r_pc + ADDR_W'(4);
  assign w_pc_target = r_pc + r_imm[ADDR_W-1:0];
  assign w_taken     = (w_cls == CLS_BEQ) ? (r_a == r_b) : (r_a != r_b);

  assign w_rf_we    = (r_state == WB) && !Rst;
  assign w_rf_wdata = (w_cls == CLS_LW) ? r_mdr : r_alu_out;

  mc_regfile #(.XLEN(XLEN)) u_regfile (
    .i_clk    (Clk),
    .i_raddr1 (w_rs1),
    .i_raddr2 (w_rs2),
    .o_rdata1 (w_rs1_data),
    .o_rdata2 (w_rs2_data),
    .i_we     (w_rf_we),
    .i_waddr  (w_rd),
    .i_wdata  (w_rf_wdata)
  );

  // Control FSM with registered memory-port outputs; the request for the
  // next state is set up on the transition into FETCH or MEM.
  // NOTE: all state here uses non-blocking assignments so every register
  // sees the pre-edge values of the others, regardless of statement order.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_state     <= FETCH;
      r_pc        <= ADDR_W'(RESET_PC);
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_halted    <= 1'b0;
      r_instret   <= '0;
    end else begin
      case (r_state)
        FETCH: begin
          if (!r_mem_req) begin
            // First fetch after reset: raise the request for the reset PC.
            r_mem_req  <= 1'b1;
            r_mem_we   <= 1'b0;
            r_mem_addr <= r_pc;
          end else if (Mem_Ready) begin
            r_ir      <= Mem_Rdata;
            r_mem_req <= 1'b0;
            r_state   <= DECODE;
          end
        end
        DECODE: begin
          r_a   <= w_rs1_data;
          r_b   <= w_rs2_data;
          r_imm <= w_imm;
          if (w_cls == CLS_ILL) begin
            r_halted <= 1'b1;
            r_state  <= HALT;
          end else begin
            r_state <= EXEC;
          end
        end
        EXEC: begin
          case (w_cls)
            CLS_R, CLS_ADDI: begin
              r_alu_out <= w_alu_result;
              r_state   <= WB;
            end
            CLS_LW, CLS_SW: begin
              r_alu_out <= w_alu_result;
              if (w_alu_result[1:0] != 2'b00) begin
                r_halted <= 1'b1;
                r_state  <= HALT;
              end else begin
                r_mem_req   <= 1'b1;
                r_mem_we    <= (w_cls == CLS_SW);
                r_mem_addr  <= w_alu_result[ADDR_W-1:0];
                r_mem_wdata <= r_b;
                r_state     <= MEM;
              end
            end
            CLS_BEQ, CLS_BNE: begin
              if (w_taken && (w_pc_target[1:0] != 2'b00)) begin
                r_halted <= 1'b1;
                r_state  <= HALT;
              end else begin
                r_pc       <= w_taken ? w_pc_target : w_pc_plus4;
                r_mem_req  <= 1'b1;
                r_mem_we   <= 1'b0;
                r_mem_addr <= w_taken ? w_pc_target : w_pc_plus4;
                r_instret  <= r_instret + 32'd1;
                r_state    <= FETCH;
              end
            end
            CLS_JAL: begin
              if (w_pc_target[1:0] != 2'b00) begin
                r_halted <= 1'b1;
                r_state  <= HALT;
              end else begin
                r_alu_out <= XLEN'(w_pc_plus4);
                r_pc      <= w_pc_target;
                r_state   <= WB;
              end
            end
            default: begin
              r_halted <= 1'b1;
              r_state  <= HALT;
            end
          endcase
        end
        MEM: begin
          if (Mem_Ready) begin
            if (r_mem_we) begin
              // Store retires here and the request rolls straight into fetch.
              r_pc       <= w_pc_plus4;
              r_mem_we   <= 1'b0;
              r_mem_addr <= w_pc_plus4;
              r_instret  <= r_instret + 32'd1;
              r_state    <= FETCH;
            end else begin
              r_mdr     <= Mem_Rdata;
              r_mem_req <= 1'b0;
              r_state   <= WB;
            end
          end
        end
        WB: begin
          // jal already moved the PC in EXEC.
          r_pc       <= (w_cls == CLS_JAL) ? r_pc : w_pc_plus4;
          r_mem_req  <= 1'b1;
          r_mem_we   <= 1'b0;
          r_mem_addr <= (w_cls == CLS_JAL) ? r_pc : w_pc_plus4;
          r_instret  <= r_instret + 32'd1;
          r_state    <= FETCH;
        end
        HALT: begin
          r_halted  <= 1'b1;
          r_mem_req <= 1'b0;
        end
        default: begin
          r_halted  <= 1'b1;
          r_mem_req <= 1'b0;
          r_state   <= HALT;
        end
      endcase
    end
  end

  assign Mem_Req   = r_mem_req;
  assign Mem_We    = r_mem_we;
  assign Mem_Addr  = r_mem_addr;
  assign Mem_Wdata = r_mem_wdata;
  assign Halted    = r_halted;
  assign Instret   = r_instret;
  assign Dbg_PC    = r_pc;

endmodule

// File: tb/tb_multicycle_rv_core.sv
// Self-checking bench for multicycle_rv_core: a table of small programs whose
// results are observed through stores, plus hand-written timing sequences.
module tb_multicycle_rv_core;

  logic        Clk = 1'b0;
  logic        Rst = 1'b1;
  logic        Mem_Req;
  logic        Mem_We;
  logic [15:0] Mem_Addr;
  logic [31:0] Mem_Wdata;
  logic        Mem_Ready = 1'b0;
  logic [31:0] Mem_Rdata = '0;
  logic        Halted;
  logic [31:0] Instret;
  logic [15:0] Dbg_PC;

  multicycle_rv_core #(.XLEN(32), .ADDR_W(16), .RESET_PC(0)) dut (
    .Clk       (Clk),
    .Rst       (Rst),
    .Mem_Req   (Mem_Req),
    .Mem_We    (Mem_We),
    .Mem_Addr  (Mem_Addr),
    .Mem_Wdata (Mem_Wdata),
    .Mem_Ready (Mem_Ready),
    .Mem_Rdata (Mem_Rdata),
    .Halted    (Halted),
    .Instret   (Instret),
    .Dbg_PC    (Dbg_PC)
  );

  always #5 Clk = ~Clk;

  // Memory model: 64 words; data region starts at byte 0x80.
  logic [31:0] mem [64];
  logic [31:0] img [64];
  bit          do_load = 1'b0;
  bit          tie_ready = 1'b0;
  int          data_wait = 0;
  int          wait_cnt = 0;
  bit          hs = 1'b0;
  logic [15:0] fetch_log [$];

  always @(posedge Clk) begin
    if (do_load) begin
      for (int i = 0; i < 64; i++) mem[i] = img[i];
      fetch_log.delete();
    end
    hs = Mem_Req && Mem_Ready;
    if (hs && Mem_We) mem[Mem_Addr[7:2]] = Mem_Wdata;
    if (hs && !Mem_We && (Mem_Addr < 16'h0080)) fetch_log.push_back(Mem_Addr);
  end

  always @(negedge Clk) begin
    if (hs) wait_cnt = 0;
    if (tie_ready) Mem_Ready = 1'b1;
    else if (!Mem_Req) Mem_Ready = 1'b0;
    else if ((Mem_Addr >= 16'h0080) && (wait_cnt < data_wait)) begin
      Mem_Ready = 1'b0;
      wait_cnt++;
    end else Mem_Ready = 1'b1;
    Mem_Rdata = mem[Mem_Addr[7:2]];
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(negedge Clk);
    #1;
  endtask

  // Hold reset, load the image, release reset.
  task automatic start();
    step();
    Rst = 1'b1;
    do_load = 1'b1;
    step();
    do_load = 1'b0;
    step();
    Rst = 1'b0;
  endtask

  task automatic run_halt(input string name, input int budget);
    int n;
    n = 0;
    while (!Halted && n < budget) begin
      step();
      n++;
    end
    check({name, " halt reached"}, {31'd0, Halted}, 32'd1);
  endtask

  // Tiny assembler.
  function automatic logic [31:0] a_r(input int f7, input int f3, input int rd, input int rs1, input int rs2);
    logic [6:0] t7;
    logic [2:0] t3;
    t7 = f7[6:0];
    t3 = f3[2:0];
    return {t7, rs2[4:0], rs1[4:0], t3, rd[4:0], 7'b0110011};
  endfunction
  function automatic logic [31:0] a_addi(input int rd, input int rs1, input int imm);
    logic [11:0] t;
    t = imm[11:0];
    return {t, rs1[4:0], 3'b000, rd[4:0], 7'b0010011};
  endfunction
  function automatic logic [31:0] a_lw(input int rd, input int rs1, input int imm);
    logic [11:0] t;
    t = imm[11:0];
    return {t, rs1[4:0], 3'b010, rd[4:0], 7'b0000011};
  endfunction
  function automatic logic [31:0] a_sw(input int rs2, input int rs1, input int imm);
    logic [11:0] t;
    t = imm[11:0];
    return {t[11:5], rs2[4:0], rs1[4:0], 3'b010, t[4:0], 7'b0100011};
  endfunction
  function automatic logic [31:0] a_br(input int f3, input int rs1, input int rs2, input int imm);
    logic [12:0] t;
    logic [2:0]  t3;
    t  = imm[12:0];
    t3 = f3[2:0];
    return {t[12], t[10:5], rs2[4:0], rs1[4:0], t3, t[4:1], t[11], 7'b1100011};
  endfunction
  function automatic logic [31:0] a_jal(input int rd, input int imm);
    logic [20:0] t;
    t = imm[20:0];
    return {t[20], t[10:1], t[11], t[19:12], rd[4:0], 7'b1101111};
  endfunction

  typedef struct {
    logic [5:0][31:0] prog;
    int               wt;
    int               n_ret;
    logic [31:0]      exp;
  } vec_t;

  vec_t vecs [13];

  initial begin
    int          n;
    int          stalls;
    int          addr_bad;
    bit          req_seen;
    logic [31:0] got;

    // Program table; every program ends by storing its result to 0x80.
    for (int i = 0; i < 13; i++) begin
      vecs[i].prog = '0;
      vecs[i].wt   = 0;
    end
    vecs[0].prog[0] = a_addi(1, 0, 5);   vecs[0].prog[1] = a_addi(2, 0, 7);
    vecs[0].prog[2] = a_r(0, 0, 3, 1, 2); vecs[0].prog[3] = a_sw(3, 0, 128);
    vecs[0].n_ret = 4; vecs[0].exp = 32'd12;
    vecs[1].prog = vecs[0].prog; vecs[1].prog[2] = a_r(32, 0, 3, 1, 2);
    vecs[1].n_ret = 4; vecs[1].exp = 32'hFFFF_FFFE; vecs[1].wt = 1;
    vecs[2].prog[0] = a_addi(1, 0, 12);  vecs[2].prog[1] = a_addi(2, 0, 10);
    vecs[2].prog[2] = a_r(0, 7, 3, 1, 2); vecs[2].prog[3] = a_sw(3, 0, 128);
    vecs[2].n_ret = 4; vecs[2].exp = 32'd8;
    vecs[3].prog = vecs[2].prog; vecs[3].prog[2] = a_r(0, 6, 3, 1, 2);
    vecs[3].n_ret = 4; vecs[3].exp = 32'd14;
    vecs[4].prog[0] = a_addi(5, 0, -1);  vecs[4].prog[1] = a_addi(1, 0, 5);
    vecs[4].prog[2] = a_r(0, 2, 3, 5, 1); vecs[4].prog[3] = a_sw(3, 0, 128);
    vecs[4].n_ret = 4; vecs[4].exp = 32'd1;
    vecs[5].prog = vecs[4].prog; vecs[5].prog[2] = a_r(0, 2, 3, 1, 5);
    vecs[5].n_ret = 4; vecs[5].exp = 32'd0;
    vecs[6].prog[0] = a_addi(0, 0, 9);   vecs[6].prog[1] = a_sw(0, 0, 128);
    vecs[6].n_ret = 2; vecs[6].exp = 32'd0;
    vecs[7].prog[0] = a_addi(1, 0, -2048); vecs[7].prog[1] = a_r(0, 0, 3, 1, 1);
    vecs[7].prog[2] = a_sw(3, 0, 128);
    vecs[7].n_ret = 3; vecs[7].exp = 32'hFFFF_F000;
    vecs[8].prog[0] = a_addi(1, 0, 77);  vecs[8].prog[1] = a_sw(1, 0, 132);
    vecs[8].prog[2] = a_lw(3, 0, 132);   vecs[8].prog[3] = a_sw(3, 0, 128);
    vecs[8].n_ret = 4; vecs[8].exp = 32'd77; vecs[8].wt = 2;
    vecs[9].prog[0] = a_addi(3, 0, 1);   vecs[9].prog[1] = a_br(0, 0, 0, 8);
    vecs[9].prog[2] = a_addi(3, 0, 5);   vecs[9].prog[3] = a_sw(3, 0, 128);
    vecs[9].n_ret = 3; vecs[9].exp = 32'd1;
    vecs[10].prog = vecs[9].prog; vecs[10].prog[1] = a_br(1, 0, 0, 8);
    vecs[10].n_ret = 4; vecs[10].exp = 32'd5;
    vecs[11].prog = vecs[9].prog; vecs[11].prog[1] = a_br(1, 3, 0, 8);
    vecs[11].n_ret = 3; vecs[11].exp = 32'd1;
    vecs[12].prog[0] = a_jal(1, 8);      vecs[12].prog[1] = a_addi(1, 0, 99);
    vecs[12].prog[2] = a_sw(1, 0, 128);
    vecs[12].n_ret = 2; vecs[12].exp = 32'd4;

    // Sequence 1: reset with Ready tied high, then the 16-cycle timing.
    for (int i = 0; i < 64; i++) img[i] = '0;
    for (int j = 0; j < 6; j++) img[j] = vecs[0].prog[j];
    tie_ready = 1'b1;
    start();
    check("reset req low", {31'd0, Mem_Req}, 32'd0);
    check("reset halted", {31'd0, Halted}, 32'd0);
    check("reset instret", Instret, 32'd0);
    n = 0;
    while (!Mem_Req && n < 5) begin
      step();
      n++;
    end
    check("first fetch req", {31'd0, Mem_Req}, 32'd1);
    check("first fetch addr", {16'd0, Mem_Addr}, 32'h0000_0000);
    repeat (15) step();
    check("instret after 15 cycles", Instret, 32'd3);
    step();
    check("instret after 16 cycles", Instret, 32'd4);
    run_halt("seq1", 40);
    check("seq1 store", mem[32], 32'd12);
    tie_ready = 1'b0;

    // Table: one program per entry.
    for (int v = 0; v < 13; v++) begin
      for (int i = 0; i < 64; i++) img[i] = '0;
      for (int j = 0; j < 6; j++) img[j] = vecs[v].prog[j];
      img[32] = 32'hDEAD_BEEF;
      data_wait = vecs[v].wt;
      start();
      run_halt($sformatf("vec%0d", v), 200);
      check($sformatf("vec%0d result", v), mem[32], vecs[v].exp);
      check($sformatf("vec%0d instret", v), Instret, vecs[v].n_ret);
    end

    // Sequence 2: lw with three wait cycles in MEM.
    for (int i = 0; i < 64; i++) img[i] = '0;
    img[0] = a_lw(4, 0, 128);
    img[1] = a_sw(4, 0, 132);
    img[32] = 32'd12;
    data_wait = 3;
    start();
    n = 0;
    while (!Mem_Req && n < 5) begin
      step();
      n++;
    end
    n = 0;
    stalls = 0;
    addr_bad = 0;
    while (Instret != 32'd1 && n < 30) begin
      step();
      n++;
      if (Mem_Req && !Mem_Ready) begin
        stalls++;
        if (Mem_Addr != 16'h0080 || Mem_We) addr_bad++;
      end
    end
    check("lw cycles", n, 32'd8);
    check("lw stall cycles", stalls, 32'd3);
    check("lw addr stable", addr_bad, 32'd0);
    run_halt("lw", 60);
    check("lw value", mem[33], 32'd12);
    data_wait = 0;

    // Sequence 3: jal x1,-4 at 0x10.
    for (int i = 0; i < 64; i++) img[i] = '0;
    img[0] = a_jal(0, 16);
    img[4] = a_jal(1, -4);
    img[3] = a_sw(1, 0, 128);
    start();
    n = 0;
    while (Instret != 32'd3 && n < 40) begin
      step();
      n++;
    end
    check("jal retire count", Instret, 32'd3);
    got = (fetch_log.size() >= 3) ? {16'd0, fetch_log[2]} : 32'hFFFF_FFFF;
    check("jal target fetch", got, 32'h0000_000C);
    check("jal link", mem[32], 32'h0000_0014);

    // Sequence 4: illegal opcode halts and stays halted.
    for (int i = 0; i < 64; i++) img[i] = '0;
    img[0] = 32'hFFFF_FFFF;
    start();
    run_halt("illegal", 20);
    req_seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (Mem_Req || !Halted) req_seen = 1'b1;
    end
    check("illegal stays halted no req", {31'd0, req_seen}, 32'd0);
    check("illegal instret", Instret, 32'd0);

    // Sequence 5: misaligned lw halts before any data request.
    for (int i = 0; i < 64; i++) img[i] = '0;
    img[0] = a_lw(1, 0, 6);
    start();
    check("reset clears halted", {31'd0, Halted}, 32'd0);
    run_halt("misaligned lw", 20);
    repeat (3) step();
    check("misaligned lw accesses", fetch_log.size(), 32'd1);
    check("misaligned lw req", {31'd0, Mem_Req}, 32'd0);
    check("misaligned lw instret", Instret, 32'd0);

    // Sequence 6: taken branch to a misaligned target.
    for (int i = 0; i < 64; i++) img[i] = '0;
    img[0] = a_br(0, 0, 0, 6);
    start();
    run_halt("misaligned branch", 20);
    check("misaligned branch pc", {16'd0, Dbg_PC}, 32'd0);
    check("misaligned branch instret", Instret, 32'd0);

    // Sequence 7: recovery from halt restarts at the reset PC.
    for (int i = 0; i < 64; i++) img[i] = '0;
    for (int j = 0; j < 6; j++) img[j] = vecs[0].prog[j];
    start();
    run_halt("recovery", 60);
    check("recovery first fetch", (fetch_log.size() > 0) ? {16'd0, fetch_log[0]} : 32'hFFFF_FFFF, 32'd0);
    check("recovery result", mem[32], 32'd12);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
